// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI bus arbiter and its helpers.
package pci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ACTIVE,
        ST_DRAIN
    } arb_state_t;

    // PCI control lines are active-low.
    localparam logic PCI_ASSERTED   = 1'b0;
    localparam logic PCI_DEASSERTED = 1'b1;

    localparam int PCI_DEF_GNT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_picker.sv
// Circular priority encoder over active-low requests, starting at ptr.
module pci_rr_picker
    import pci_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_n,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    int               w_idx_int;
    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest slot back to ptr so the closest requester is written last.
    always_comb begin
        winner    = ptr;
        any_req   = 1'b0;
        w_idx_int = 0;
        w_idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx_int = int'(ptr) + k;
            if (w_idx_int >= N) begin
                w_idx_int = w_idx_int - N;
            end
            w_idx = PTR_W'(w_idx_int);
            if (req_n[w_idx] == PCI_ASSERTED) begin
                winner  = w_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and bus-ownership tracking.
// Optional bus parking on an idle bus is enabled by defining PCI_ARB_PARK_EN.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = PCI_DEF_GNT_TIMEOUT,
    parameter int PARK_MASTER = 0
) (
    input  logic                         Clock,
    input  logic                         RST,
    input  logic [N_MASTERS-1:0]         Req,
    input  logic                         Frame,
    input  logic                         Irdy,
    output logic [N_MASTERS-1:0]         Gnt,
    output logic [$clog2(N_MASTERS)-1:0] BusOwner,
    output logic                         BusIdle
);

    localparam int OWN_W = $clog2(N_MASTERS);
    localparam int TMR_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] GNT_NONE = '1;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [N_MASTERS-1:0]  r_gnt;
    logic [N_MASTERS-1:0]  w_gnt_nxt;
    logic [OWN_W-1:0]      r_owner;
    logic [OWN_W-1:0]      w_owner_nxt;
    logic [OWN_W-1:0]      r_ptr;
    logic [OWN_W-1:0]      w_ptr_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic                  r_idle;

    logic                  w_idle_now;
    logic [OWN_W-1:0]      w_winner;
    logic                  w_any_req;
    logic                  w_own_req;
    logic                  w_other_req;
    logic [N_MASTERS-1:0]  w_owner_mask;

    function automatic logic [N_MASTERS-1:0] gnt_for(input logic [OWN_W-1:0] idx);
        return ~(N_MASTERS'(1) << idx);
    endfunction

    pci_rr_picker #(
        .N     (N_MASTERS),
        .PTR_W (OWN_W)
    ) u_picker (
        .req_n   (Req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    assign w_idle_now   = (Frame == PCI_DEASSERTED) && (Irdy == PCI_DEASSERTED);
    assign w_owner_mask = N_MASTERS'(1) << r_owner;
    assign w_own_req    = (Req[r_owner] == PCI_ASSERTED);
    // Masking the owner's bit high leaves only competing requests low.
    assign w_other_req  = |(~(Req | w_owner_mask));

`ifdef PCI_ARB_PARK_EN
    logic w_parked;
    assign w_parked = (r_gnt != GNT_NONE);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_timer_nxt = r_timer;

        unique case (r_state)
            ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (w_parked && Frame == PCI_ASSERTED) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_any_req && w_parked) begin
                    // Unpark first so the new winner gets a turnaround cycle.
                    w_gnt_nxt = GNT_NONE;
                end else if (w_any_req) begin
                    w_gnt_nxt   = gnt_for(w_winner);
                    w_owner_nxt = w_winner;
                    w_timer_nxt = '0;
                    w_ptr_nxt   = (w_winner == OWN_W'(N_MASTERS - 1)) ? '0 : w_winner + 1'b1;
                    w_state_nxt = ST_GRANT;
                end else if (w_idle_now) begin
                    w_gnt_nxt   = gnt_for(OWN_W'(PARK_MASTER));
                    w_owner_nxt = OWN_W'(PARK_MASTER);
                end
`else
                if (w_any_req) begin
                    w_gnt_nxt   = gnt_for(w_winner);
                    w_owner_nxt = w_winner;
                    w_timer_nxt = '0;
                    w_ptr_nxt   = (w_winner == OWN_W'(N_MASTERS - 1)) ? '0 : w_winner + 1'b1;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_gnt_nxt = GNT_NONE;
                end
`endif
            end
            ST_GRANT: begin
                if (Frame == PCI_ASSERTED) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (!w_own_req) begin
                    w_gnt_nxt   = GNT_NONE;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == TMR_LAST && w_idle_now) begin
                    w_gnt_nxt   = GNT_NONE;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer != TMR_LAST) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_other_req || !w_own_req) begin
                    w_gnt_nxt   = GNT_NONE;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_gnt_nxt = GNT_NONE;
                if (w_idle_now) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = GNT_NONE;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_NONE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_timer <= '0;
            r_idle  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_timer <= w_timer_nxt;
            r_idle  <= w_idle_now;
        end
    end

    assign Gnt      = r_gnt;
    assign BusOwner = r_owner;
    assign BusIdle  = r_idle;

    a_park_idx: assert property (@(posedge Clock) PARK_MASTER < N_MASTERS);

    a_one_gnt: assert property (@(posedge Clock) disable iff (RST)
        $countones(~Gnt) <= 1);

    // A grant may only move to another master through an all-deasserted cycle.
    a_dead_cycle: assert property (@(posedge Clock) disable iff (RST)
        (Gnt != GNT_NONE && $past(Gnt) != GNT_NONE) |-> (Gnt == $past(Gnt)));

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: behavioural model plus directed scenarios.
module tb_pci_bus_arbiter;

    localparam int NM = 4;
    localparam int TO = 16;

    logic          Clock;
    logic          RST;
    logic [NM-1:0] Req;
    logic          Frame;
    logic          Irdy;
    logic [NM-1:0] Gnt;
    logic [1:0]    BusOwner;
    logic          BusIdle;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who holds the grant (-1 none), whether the holder has started using
    // the bus, whether a preempted transaction is still finishing, and the
    // round-robin start position.
    int m_holder = -1;
    int m_rr     = 0;
    int m_wait   = 0;
    int m_owner  = 0;
    bit m_inuse  = 0;
    bit m_finish = 0;
    bit m_busidle = 1;

    pci_bus_arbiter dut (
        .Clock    (Clock),
        .RST      (RST),
        .Req      (Req),
        .Frame    (Frame),
        .Irdy     (Irdy),
        .Gnt      (Gnt),
        .BusOwner (BusOwner),
        .BusIdle  (BusIdle)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit quiet;
        bit rival;
        int m;
        quiet = Frame && Irdy;
        if (RST) begin
            m_holder  = -1;
            m_rr      = 0;
            m_wait    = 0;
            m_owner   = 0;
            m_inuse   = 0;
            m_finish  = 0;
            m_busidle = 1;
            return;
        end
        m_busidle = quiet;
        if (m_finish) begin
            if (quiet) m_finish = 0;
        end else if (m_holder < 0) begin
            for (int k = 0; k < NM; k++) begin
                m = (m_rr + k) % NM;
                if (m_holder < 0 && Req[m] == 1'b0) begin
                    m_holder = m;
                    m_owner  = m;
                    m_rr     = (m + 1) % NM;
                    m_wait   = 0;
                    m_inuse  = 0;
                end
            end
        end else if (!m_inuse) begin
            if (!Frame) m_inuse = 1;
            else if (Req[m_holder]) m_holder = -1;
            else if (m_wait >= TO - 1 && quiet) m_holder = -1;
            else m_wait++;
        end else begin
            rival = 0;
            for (int k = 0; k < NM; k++)
                if (k != m_holder && Req[k] == 1'b0) rival = 1;
            if (rival || Req[m_holder]) begin
                m_holder = -1;
                m_inuse  = 0;
                m_finish = 1;
            end
        end
    endtask

    // Model follows every rising edge; outputs are compared half a cycle later.
    initial begin
        logic [NM-1:0] exp_gnt;
        forever begin
            @(posedge Clock);
            model_step();
            @(negedge Clock);
            exp_gnt = '1;
            if (m_holder >= 0) exp_gnt[m_holder] = 1'b0;
            check("cyc_gnt", Gnt, exp_gnt);
            check("cyc_owner", BusOwner, m_owner);
            check("cyc_busidle", BusIdle, m_busidle);
        end
    end

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        repeat (cycles) @(negedge Clock);
        RST = 1'b0;
    endtask

    initial begin
        logic [NM-1:0] rr_exp [5];
        int cnt;
        int mode;
        rr_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        RST = 1'b1; Req = '1; Frame = 1'b1; Irdy = 1'b1;
        repeat (3) @(negedge Clock);
        check("reset_gnt", Gnt, 4'b1111);
        check("reset_owner", BusOwner, 0);
        check("reset_busidle", BusIdle, 1);
        RST = 1'b0;

        // Timeout on an idle grant, then regrant of the same master.
        Req = 4'b1101;
        cnt = 0;
        @(negedge Clock);
        while (Gnt == 4'b1101 && cnt < 40) begin
            cnt++;
            @(negedge Clock);
        end
        check("timeout_len", cnt, 16);
        check("timeout_revoke", Gnt, 4'b1111);
        @(negedge Clock);
        check("timeout_regrant", Gnt, 4'b1101);
        check("timeout_owner", BusOwner, 1);
        Req = 4'b1111;
        repeat (2) @(negedge Clock);

        // Withdrawal one clock after the grant.
        do_reset(1);
        Req = 4'b1110;
        @(negedge Clock);
        check("wd_grant", Gnt, 4'b1110);
        Req = 4'b1111;
        @(negedge Clock);
        check("wd_release", Gnt, 4'b1111);
        Req = 4'b1101;
        @(negedge Clock);
        check("wd_idle_regrant", Gnt, 4'b1101);
        Req = 4'b1111;
        repeat (2) @(negedge Clock);

        // Preemption of an active master.
        do_reset(1);
        Req = 4'b1110;
        @(negedge Clock);
        check("pre_grant", Gnt, 4'b1110);
        Frame = 1'b0; Irdy = 1'b0;
        @(negedge Clock);
        Req = 4'b1010;
        @(negedge Clock);
        check("pre_release", Gnt, 4'b1111);
        repeat (2) begin
            @(negedge Clock);
            check("pre_drain", Gnt, 4'b1111);
        end
        Frame = 1'b1; Irdy = 1'b1;
        @(negedge Clock);
        check("pre_idle", Gnt, 4'b1111);
        @(negedge Clock);
        check("pre_next", Gnt, 4'b1011);
        check("pre_owner", BusOwner, 2);
        Req = 4'b1111;
        repeat (3) @(negedge Clock);

        // Reset in the middle of a transaction by master 2.
        do_reset(1);
        Req = 4'b1011;
        @(negedge Clock);
        check("mid_grant", Gnt, 4'b1011);
        Frame = 1'b0; Irdy = 1'b0;
        @(negedge Clock);
        check("mid_busidle_low", BusIdle, 0);
        RST = 1'b1;
        @(negedge Clock);
        check("mid_rst_gnt", Gnt, 4'b1111);
        check("mid_rst_owner", BusOwner, 0);
        check("mid_rst_busidle", BusIdle, 1);
        RST = 1'b0; Req = 4'b0110; Frame = 1'b1; Irdy = 1'b1;
        @(negedge Clock);
        check("mid_after_gnt", Gnt, 4'b1110);
        Req = 4'b1111;
        repeat (3) @(negedge Clock);

        // Round-robin with every master requesting.
        do_reset(1);
        Req = 4'b0000;
        for (int t = 0; t < 5; t++) begin
            cnt = 0;
            @(negedge Clock);
            while (Gnt == 4'b1111 && cnt < 10) begin
                cnt++;
                @(negedge Clock);
            end
            check("rr_gnt", Gnt, rr_exp[t]);
            if (t > 0) check("rr_dead_cycle", (cnt > 0), 1);
            Frame = 1'b0; Irdy = 1'b0;
            @(negedge Clock);
            @(negedge Clock);
            Frame = 1'b1; Irdy = 1'b1;
        end
        Req = 4'b1111;
        repeat (3) @(negedge Clock);

        // Randomized segments: chaotic, idle-bus (timeouts), transaction-like.
        for (int seg = 0; seg < 15; seg++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 200; c++) begin
                @(negedge Clock);
                RST = ($urandom_range(0, 199) == 0);
                case (mode)
                    0: begin
                        Req   = 4'($urandom);
                        Frame = 1'($urandom);
                        Irdy  = ($urandom_range(0, 3) != 0) ? Frame : 1'($urandom);
                    end
                    1: begin
                        Frame = 1'b1;
                        Irdy  = 1'b1;
                        if ($urandom_range(0, 29) == 0) Req = 4'($urandom);
                    end
                    default: begin
                        if ($urandom_range(0, 9) == 0) Req = 4'($urandom);
                        if ($urandom_range(0, 4) == 0) Frame = ~Frame;
                        Irdy = Frame;
                    end
                endcase
            end
        end
        RST = 1'b0; Req = '1; Frame = 1'b1; Irdy = 1'b1;
        repeat (4) @(negedge Clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
